// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM config sequencer.
package pwm_seq_pkg;

    // Sequencer states: one strobe cycle and one hold cycle per byte.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DISABLE = 4'd1,
        ST_PL_STB  = 4'd2,
        ST_PL_HOLD = 4'd3,
        ST_PH_STB  = 4'd4,
        ST_PH_HOLD = 4'd5,
        ST_IL_STB  = 4'd6,
        ST_IL_HOLD = 4'd7,
        ST_IH_STB  = 4'd8,
        ST_IH_HOLD = 4'd9,
        ST_ENABLE  = 4'd10,
        ST_ACK     = 4'd11
    } state_e;

    // Bit positions of the byte write strobes inside the WE vector.
    localparam int BYTE_PL = 0;
    localparam int BYTE_PH = 1;
    localparam int BYTE_IL = 2;
    localparam int BYTE_IH = 3;

    // Cycles from capture to the ack pulse on a full load.
    localparam int ACK_LATENCY = 11;

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Round-robin arbiter: grants the first active requester at or after i_ptr,
// wrapping to the lowest active requester when none is found above it.
module pwm_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int RR_W    = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [RR_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [RR_W-1:0]    o_idx,
    output logic               o_vld
);

    logic [RR_W-1:0] w_lo_idx;
    logic [RR_W-1:0] w_hi_idx;
    logic            w_lo_vld;
    logic            w_hi_vld;

    // Scan high-to-low so the lowest index wins in each search window.
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_hi_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx = RR_W'(i);
                w_lo_vld = 1'b1;
                if (i >= int'(i_ptr)) begin
                    w_hi_idx = RR_W'(i);
                    w_hi_vld = 1'b1;
                end
            end
        end
    end

    // Prefer the window starting at the pointer, then wrap.
    always_comb begin
        o_vld = w_lo_vld;
        o_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
        o_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_gnt[i] = o_vld && (o_idx == RR_W'(i));
        end
    end

endmodule

// File: rtl/pwm_config_sequencer.sv
// PWM timer config sequencer: arbitrates requesters and replays each granted
// period/impulse request as disable, four byte strobes, optional enable, ack.
// Optional feature macro: PWM_SEQ_CHECK_EN rejects period==0 or impuls>period
// with an err pulse and no strobes.
module pwm_config_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [16*NUM_REQ-1:0]  i_req_period,
    input  logic [16*NUM_REQ-1:0]  i_req_impuls,
    input  logic [NUM_REQ-1:0]     i_req_enable,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [NUM_REQ-1:0]     o_err,
    output logic                   o_busy,
    output logic [7:0]             o_pwm_period_low,
    output logic [7:0]             o_pwm_period_high,
    output logic [7:0]             o_pwm_impuls_low,
    output logic [7:0]             o_pwm_impuls_high,
    output logic                   o_pwm_we_period_low,
    output logic                   o_pwm_we_period_high,
    output logic                   o_pwm_we_impuls_low,
    output logic                   o_pwm_we_impuls_high,
    output logic                   o_pwm_we_enable,
    output logic                   o_pwm_we_disable
);

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [RR_W-1:0]             r_ptr;
    logic [RR_W-1:0]             r_gidx;
    logic [15:0]                 r_period;
    logic [15:0]                 r_impuls;
    logic                        r_enable;
    logic                        r_bad;
    logic [3:0]                  r_we;
    logic                        r_we_en;
    logic                        r_we_dis;
    logic [NUM_REQ-1:0]          r_ack;

    logic [NUM_REQ-1:0]          w_gnt;
    logic [RR_W-1:0]             w_gidx;
    logic                        w_gvld;
    logic                        w_capture;
    logic [NUM_REQ-1:0][15:0]    w_per_arr;
    logic [NUM_REQ-1:0][15:0]    w_imp_arr;
    logic [15:0]                 w_sel_per;
    logic [15:0]                 w_sel_imp;
    logic                        w_bad;
    logic [3:0]                  w_we_nxt;
    logic                        w_we_en_nxt;
    logic                        w_we_dis_nxt;
    logic                        w_ack_fire;
    logic [NUM_REQ-1:0]          w_gidx_oh;

    pwm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RR_W    (RR_W)
    ) u_arb (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_vld (w_gvld)
    );

    assign w_capture = (r_state == ST_IDLE) && w_gvld;
    assign w_per_arr = i_req_period;
    assign w_imp_arr = i_req_impuls;
    assign w_sel_per = w_per_arr[w_gidx];
    assign w_sel_imp = w_imp_arr[w_gidx];

`ifdef PWM_SEQ_CHECK_EN
    assign w_bad = (w_sel_per == 16'd0) || (w_sel_imp > w_sel_per);
`else
    assign w_bad = 1'b0;
`endif

    // One-hot of the latched grant, used to route ack/err back.
    always_comb begin
        w_gidx_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gidx_oh[i] = (r_gidx == RR_W'(i));
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus next-cycle strobes; strobes are registered so the
    // timer sees glitch-free WE lines aligned with the state they belong to.
    always_comb begin
        w_state_nxt  = r_state;
        w_we_nxt     = '0;
        w_we_en_nxt  = 1'b0;
        w_we_dis_nxt = 1'b0;
        w_ack_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gvld) begin
                    w_state_nxt  = ST_DISABLE;
                    w_we_dis_nxt = !w_bad;
                end
            end
            ST_DISABLE: begin
                if (r_bad) begin
                    w_state_nxt = ST_ACK;
                    w_ack_fire  = 1'b1;
                end else begin
                    w_state_nxt       = ST_PL_STB;
                    w_we_nxt[BYTE_PL] = 1'b1;
                end
            end
            ST_PL_STB:  w_state_nxt = ST_PL_HOLD;
            ST_PL_HOLD: begin
                w_state_nxt       = ST_PH_STB;
                w_we_nxt[BYTE_PH] = 1'b1;
            end
            ST_PH_STB:  w_state_nxt = ST_PH_HOLD;
            ST_PH_HOLD: begin
                w_state_nxt       = ST_IL_STB;
                w_we_nxt[BYTE_IL] = 1'b1;
            end
            ST_IL_STB:  w_state_nxt = ST_IL_HOLD;
            ST_IL_HOLD: begin
                w_state_nxt       = ST_IH_STB;
                w_we_nxt[BYTE_IH] = 1'b1;
            end
            ST_IH_STB:  w_state_nxt = ST_IH_HOLD;
            ST_IH_HOLD: begin
                w_state_nxt = ST_ENABLE;
                w_we_en_nxt = r_enable;
            end
            ST_ENABLE: begin
                w_state_nxt = ST_ACK;
                w_ack_fire  = 1'b1;
            end
            ST_ACK:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the granted request and advance the round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_period <= '0;
            r_impuls <= '0;
            r_enable <= 1'b0;
            r_bad    <= 1'b0;
        end else if (w_capture) begin
            r_ptr    <= (w_gidx == RR_W'(NUM_REQ - 1)) ? '0 : w_gidx + RR_W'(1);
            r_gidx   <= w_gidx;
            r_period <= w_sel_per;
            r_impuls <= w_sel_imp;
            r_enable <= i_req_enable[w_gidx];
            r_bad    <= w_bad;
        end
    end

    // Registered strobes and ack; reset drops them asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we     <= '0;
            r_we_en  <= 1'b0;
            r_we_dis <= 1'b0;
            r_ack    <= '0;
        end else begin
            r_we     <= w_we_nxt;
            r_we_en  <= w_we_en_nxt;
            r_we_dis <= w_we_dis_nxt;
            r_ack    <= w_ack_fire ? w_gidx_oh : '0;
        end
    end

`ifdef PWM_SEQ_CHECK_EN
    logic [NUM_REQ-1:0] r_err;

    // Reject pulse accompanies the ack of a request that failed the check.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_err <= '0;
        else          r_err <= (w_ack_fire && r_bad) ? w_gidx_oh : '0;
    end

    assign o_err = r_err;
`else
    assign o_err = '0;
`endif

    assign o_ack                = r_ack;
    assign o_busy               = (r_state != ST_IDLE);
    assign o_pwm_period_low     = r_period[7:0];
    assign o_pwm_period_high    = r_period[15:8];
    assign o_pwm_impuls_low     = r_impuls[7:0];
    assign o_pwm_impuls_high    = r_impuls[15:8];
    assign o_pwm_we_period_low  = r_we[BYTE_PL];
    assign o_pwm_we_period_high = r_we[BYTE_PH];
    assign o_pwm_we_impuls_low  = r_we[BYTE_IL];
    assign o_pwm_we_impuls_high = r_we[BYTE_IH];
    assign o_pwm_we_enable      = r_we_en;
    assign o_pwm_we_disable     = r_we_dis;

endmodule

// File: tb/tb_pwm_config_sequencer.sv
// Self-checking bench for pwm_config_sequencer (NUM_REQ=2).
module tb_pwm_config_sequencer;

    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [16*NR-1:0]  per = '0;
    logic [16*NR-1:0]  imp = '0;
    logic [NR-1:0]     en = '0;
    logic [NR-1:0]     ack, err;
    logic              busy;
    logic [7:0]        pl_d, ph_d, il_d, ih_d;
    logic              we_pl, we_ph, we_il, we_ih, we_en, we_dis;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;

    pwm_config_sequencer #(.NUM_REQ(NR), .RR_W(1)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_req                (req),
        .i_req_period         (per),
        .i_req_impuls         (imp),
        .i_req_enable         (en),
        .o_ack                (ack),
        .o_err                (err),
        .o_busy               (busy),
        .o_pwm_period_low     (pl_d),
        .o_pwm_period_high    (ph_d),
        .o_pwm_impuls_low     (il_d),
        .o_pwm_impuls_high    (ih_d),
        .o_pwm_we_period_low  (we_pl),
        .o_pwm_we_period_high (we_ph),
        .o_pwm_we_impuls_low  (we_il),
        .o_pwm_we_impuls_high (we_ih),
        .o_pwm_we_enable      (we_en),
        .o_pwm_we_disable     (we_dis)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rq;
        int          g;
        logic [15:0] p;
        logic [15:0] i;
        logic        e;
        logic [31:0] exp_bytes;   // {ih, il, ph, pl}
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {ack[1:0], err[1:0], busy, dis, pl, ph, il, ih, en}
    function automatic logic [10:0] act_vec();
        return {ack, err, busy, we_dis, we_pl, we_ph, we_il, we_ih, we_en};
    endfunction

    function automatic logic [31:0] act_bytes();
        return {ih_d, il_d, ph_d, pl_d};
    endfunction

    // Expected outputs c cycles after capture for a valid load.
    function automatic logic [10:0] exp_vec(input int c, input int g, input logic e);
        logic [10:0] v;
        logic [1:0]  oh;
        oh = 2'b01 << g;
        v = '0;
        v[6] = (c >= 1 && c <= 11);
        case (c)
            1:  v[5] = 1'b1;
            2:  v[4] = 1'b1;
            4:  v[3] = 1'b1;
            6:  v[2] = 1'b1;
            8:  v[1] = 1'b1;
            10: v[0] = e;
            11: v[10:9] = oh;
            default: ;
        endcase
        return v;
    endfunction

    // Round-robin reference: first active requester at or after the pointer.
    function automatic int model_grant(input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++) begin
            int k = (m_ptr + i) % NR;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] bytes_of(input int g);
        return {imp[g*16 +: 16], per[g*16 +: 16]};
    endfunction

    task automatic wait_busy(input string nm, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: busy never rose, got 0 expected 1", nm);
        end
    endtask

    // mode 0: drop req at ack, 1: drop req in DISABLE cycle, 2: keep req high.
    task automatic check_txn(input string nm, input int g, input logic [31:0] bytes,
                             input logic e, input int mode);
        bit ok;
        wait_busy(nm, ok);
        if (!ok) begin
            req[g] = 1'b0;
            return;
        end
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("%s strobes c%0d", nm, c), 64'(act_vec()), 64'(exp_vec(c, g, e)));
            chk($sformatf("%s data c%0d", nm, c), 64'(act_bytes()), 64'(bytes));
            if (c == 1 && mode == 1) req[g] = 1'b0;
            if (c == 11 && mode == 0) req[g] = 1'b0;
        end
        m_ptr = (g + 1) % NR;
    endtask

    task automatic raise(input int k);
        int unsigned p, i;
        p = $urandom_range(1, 65535);
        i = $urandom_range(0, p);
        per[k*16 +: 16] = p[15:0];
        imp[k*16 +: 16] = i[15:0];
        en[k] = 1'($urandom_range(0, 1));
        req[k] = 1'b1;
    endtask

    initial begin
        vec_t tv[4];
        int   g;
        bit   ok;

        tv[0] = '{rq: 2'b01, g: 0, p: 16'h0123, i: 16'h0040, e: 1'b1, exp_bytes: 32'h0040_0123};
        tv[1] = '{rq: 2'b10, g: 1, p: 16'h0010, i: 16'h0008, e: 1'b0, exp_bytes: 32'h0008_0010};
        tv[2] = '{rq: 2'b10, g: 1, p: 16'hFFFF, i: 16'hFFFF, e: 1'b1, exp_bytes: 32'hFFFF_FFFF};
        tv[3] = '{rq: 2'b01, g: 0, p: 16'h0001, i: 16'h0000, e: 1'b1, exp_bytes: 32'h0000_0001};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset strobes", 64'(act_vec()), 64'd0);
        chk("reset data", 64'(act_bytes()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single-requester loads.
        for (int n = 0; n < 4; n++) begin
            per = {NR{tv[n].p}};
            imp = {NR{tv[n].i}};
            en  = {NR{tv[n].e}};
            req = tv[n].rq;
            check_txn($sformatf("vec%0d", n), tv[n].g, tv[n].exp_bytes, tv[n].e, 0);
        end

        // Contention: both held, grants alternate, no overlap between loads.
        per = {16'hA1B2, 16'h1357};
        imp = {16'h0102, 16'h0246};
        en  = 2'b01;
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            g = model_grant(req);
            check_txn($sformatf("cont%0d", n), g, bytes_of(g), en[g], 2);
        end
        req = '0;

        // Request dropped during DISABLE still completes with one ack.
        per[15:0] = 16'h0200; imp[15:0] = 16'h0010; en[0] = 1'b1;
        req = 2'b01;
        check_txn("drop", 0, 32'h0010_0200, 1'b1, 1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("drop idle%0d", n), 64'(act_vec()), 64'd0);
        end

        // Out-of-range request: rejected with the check, loaded without it.
        per[15:0] = 16'h00FF; imp[15:0] = 16'h0100; en[0] = 1'b1;
        req = 2'b01;
        g = model_grant(req);
`ifdef PWM_SEQ_CHECK_EN
        wait_busy("reject", ok);
        if (ok) begin
            chk("reject c1", 64'(act_vec()), 64'(11'b000_0100_0000));
            @(negedge clk);
            chk("reject c2", 64'(act_vec()), 64'({2'b01 << g, 2'b01 << g, 7'b100_0000}));
            req[g] = 1'b0;
            @(negedge clk);
            chk("reject c3", 64'(act_vec()), 64'd0);
            m_ptr = (g + 1) % NR;
        end else begin
            req[g] = 1'b0;
        end
`else
        check_txn("unchecked", g, 32'h0100_00FF, 1'b1, 0);
`endif

        // Randomized traffic against the round-robin reference.
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < NR; k++)
                if (!req[k] && $urandom_range(0, 1) == 1) raise(k);
            if (req == '0) raise(0);
            g = model_grant(req);
            check_txn($sformatf("rnd%0d", it), g, bytes_of(g), en[g], 0);
        end
        for (int d = 0; d < NR; d++) begin
            if (req != '0) begin
                g = model_grant(req);
                check_txn($sformatf("drain%0d", d), g, bytes_of(g), en[g], 0);
            end
        end

        // Reset during IL_STB: outputs clear immediately, pointer returns to 0.
        per[15:0] = 16'h3456; imp[15:0] = 16'h0789; en[0] = 1'b1;
        req = 2'b01;
        wait_busy("rstmid", ok);
        if (ok) begin
            repeat (5) @(negedge clk);
            chk("rstmid il_stb", 64'(act_vec()), 64'(exp_vec(6, 0, 1'b1)));
            #2 rst_n = 1'b0;
            #1;
            chk("rstmid strobes", 64'(act_vec()), 64'd0);
            chk("rstmid data", 64'(act_bytes()), 64'd0);
        end else begin
            rst_n = 1'b0;
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        per = {16'h0F0F, 16'h1111};
        imp = {16'h0101, 16'h0011};
        en  = 2'b10;
        req = 2'b11;
        g = model_grant(req);
        check_txn("post_rst", g, bytes_of(g), en[g], 0);
        g = model_grant(req);
        check_txn("post_rst2", g, bytes_of(g), en[g], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
